fragment_packer: RTL and testbench
==================================

// Module: fragment_packer
// PURPOSE
//   Packs variable-length byte fragments (0..BYTES valid bytes per beat) into dense DATA_WIDTH output beats.
//   Uses valid/ready handshakes on both sides with backpressure.
//   Supports a last/flush mode that emits a final partial beat with a byte count and end marker.
//   Sits between the row/column filter and the AXI writer in the relational cache datapath.
// PARAMETERS
//   DATA_WIDTH   512  beat width in bits; multiple of 8; BYTES = DATA_WIDTH/8
//   SIZE_WIDTH   $clog2(BYTES)+1  width of byte-count fields (holds 0..BYTES)
//   CNT_WIDTH    32   width of the output-beat counter
// PORTS
//   clock          in   1           single clock, rising edge
//   resetn         in   1           asynchronous, active-low reset
//   in_valid       in   1           fragment present
//   in_ready       out  1           fragment accepted when in_valid & in_ready
//   in_data        in   DATA_WIDTH  fragment; byte i in bits [8i+7:8i]; bytes >= in_size ignored
//   in_size        in   SIZE_WIDTH  valid bytes in fragment, 0..BYTES
//   in_last        in   1           final fragment of a stream; triggers flush
//   out_valid      out  1           packed beat present
//   out_ready      in   1           beat consumed when out_valid & out_ready
//   out_data       out  DATA_WIDTH  packed beat; byte 0 is the oldest byte; unused bytes are 0
//   out_bytes      out  SIZE_WIDTH  valid bytes in out_data (BYTES except on the last beat)
//   out_last       out  1           final beat of the stream
//   fill_level     out  SIZE_WIDTH+1 bytes currently buffered
//   beat_count     out  CNT_WIDTH   beats popped since reset; wraps modulo 2^CNT_WIDTH
//   size_err       out  1           sticky: a fragment with in_size > BYTES was accepted
// BEHAVIOUR
// - State:
//   - buf[2*DATA_WIDTH-1:0]: buffered bytes at buf[8*fill-1:0]; all bytes above fill are 0.
//   - fill: 0..2*BYTES-1.
//   - flush: 1-bit.
//   - Counter and size_err registers.
// - Reset (async, resetn=0): buf=0, fill=0, flush=0, beat_count=0, size_err=0.
//   - Outputs under reset: out_valid=0, in_ready=0, out_last=0, out_bytes=0, out_data=0.
//   - A reset mid-stream discards all buffered data immediately.
// - Output, combinational from registers only:
//   - out_valid = (fill >= BYTES) | flush
//   - out_data = buf[DATA_WIDTH-1:0]
//   - out_bytes = min(fill, BYTES)
//   - out_last = flush & (fill <= BYTES)
// - pop = out_valid & out_ready. On pop:
//   - buf >>= DATA_WIDTH (zero fill)
//   - fill -= out_bytes
//   - beat_count++
//   - if out_last, flush <= 0
// - in_ready = resetn & ~flush & ((fill < BYTES) | pop).
//   - Combinational path from out_ready to in_ready is intended; it gives full throughput.
// - push = in_valid & in_ready. On push:
//   - eff = min(in_size, BYTES); in_data bytes >= eff are masked to 0.
//   - The masked fragment is OR'd into buf at byte offset f' = fill after this cycle's pop.
//   - New fill = f' + eff.
// - Simultaneous push and pop in one cycle: pop first, then push at the post-pop offset; single update.
// - Bound: f' < BYTES at every push, so fill never exceeds 2*BYTES-1 and cannot overflow.
// - Flush:
//   - push with in_last=1 sets flush=1 and blocks further input.
//   - Beats drain; the beat with fill <= BYTES carries out_last=1.
//   - If the last push leaves fill==0, one beat with out_bytes=0, out_data=0, out_last=1 is emitted.
//   - If the last push leaves fill==BYTES exactly, that full beat carries out_last; no empty beat follows.
// - size_err: set on push with in_size > BYTES (size clamped to BYTES); cleared only by reset.
// - in_size==0 without last: accepted, no state change except handshake.
// - out_data, out_bytes and out_last hold stable while out_valid & ~out_ready.
// TESTING
// 1. DW=512, push 24,24,24 bytes (values 0x00..0x47) -> out_valid after 3rd push, out_data = bytes 0x00..0x3F,
//    out_bytes=64, out_last=0; after pop fill_level=8.
// 2. Single 24-byte fragment with in_last=1 -> next cycle out_valid, out_bytes=24, out_last=1,
//    bytes 24..63 = 0; after pop in_ready=1, fill=0, flush=0.
// 3. fill=100, out_ready=0 -> in_ready=0, out_data stable across 5 cycles;
//    raise out_ready -> same-cycle in_ready=1, push 40 bytes -> fill=76.
// 4. 16 back-to-back 64-byte fragments, out_ready=1 -> 16 beats on consecutive cycles;
//    beat_count=16; then last with size 0 -> one empty out_last beat.
// 5. in_size=70 -> 64 bytes packed, size_err=1, and it stays 1 after further valid traffic.
// 6. Assert resetn=0 asynchronously mid-cycle with fill=50, flush=1 -> all outputs 0 immediately;
//    after release, a clean 8-byte last stream outputs out_bytes=8.

Source files
------------

// File: rtl/fragment_packer.sv
// fragment_packer: packs 0..BYTES-byte fragments into dense beats.
// Handles backpressure on both sides and a last/flush tail beat.
module fragment_packer #(
   parameter int DATA_WIDTH = 512,
   parameter int SIZE_WIDTH = $clog2(DATA_WIDTH/8)+1,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [SIZE_WIDTH-1:0] in_size,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [SIZE_WIDTH-1:0] out_bytes,
   output logic                  out_last,
   output logic [SIZE_WIDTH:0]   fill_level,
   output logic [CNT_WIDTH-1:0]  beat_count,
   output logic                  size_err
);

   localparam int BYTES = DATA_WIDTH/8;
   localparam logic [SIZE_WIDTH:0]   FULL   = (SIZE_WIDTH+1)'(BYTES);
   localparam logic [SIZE_WIDTH-1:0] FULL_S = SIZE_WIDTH'(BYTES);

   logic [2*DATA_WIDTH-1:0] data_buf;
   logic [SIZE_WIDTH:0]     fill;
   logic                    flush;

   logic                    pop;
   logic                    push;
   logic [SIZE_WIDTH-1:0]   eff;
   logic [DATA_WIDTH-1:0]   mask;
   logic [SIZE_WIDTH:0]     fill_p;
   logic [2*DATA_WIDTH-1:0] buf_p;
   logic [2*DATA_WIDTH-1:0] wide;
   logic [SIZE_WIDTH+3:0]   shamt;
   logic [2*DATA_WIDTH-1:0] buf_n;
   logic [SIZE_WIDTH:0]     fill_n;

   assign out_valid  = (fill >= FULL) | flush;
   assign out_data   = data_buf[DATA_WIDTH-1:0];
   assign out_bytes  = (fill >= FULL) ? FULL_S : fill[SIZE_WIDTH-1:0];
   assign out_last   = flush & (fill <= FULL);
   assign fill_level = fill;

   assign pop      = out_valid & out_ready;
   assign in_ready = resetn & ~flush & ((fill < FULL) | pop);
   assign push     = in_valid & in_ready;
   assign eff      = (in_size > FULL_S) ? FULL_S : in_size;

   // Byte mask keeping only the first eff bytes of the fragment
   always_comb begin
      mask = '0;
      for (int i = 0; i < BYTES; i++) begin
         mask[8*i +: 8] = (i < int'(eff)) ? 8'hFF : 8'h00;
      end
   end

   // Pop first, then append the masked fragment at the post-pop offset
   always_comb begin
      buf_p  = data_buf;
      fill_p = fill;
      if (pop) begin
         buf_p  = {{DATA_WIDTH{1'b0}}, data_buf[2*DATA_WIDTH-1:DATA_WIDTH]};
         fill_p = fill - {1'b0, out_bytes};
      end
      wide   = {{DATA_WIDTH{1'b0}}, in_data & mask};
      shamt  = {fill_p, 3'b000};
      buf_n  = buf_p;
      fill_n = fill_p;
      if (push) begin
         buf_n  = buf_p | (wide << shamt);
         fill_n = fill_p + {1'b0, eff};
      end
   end

   // Buffer, fill, flush, beat counter and sticky size error
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         data_buf   <= '0;
         fill       <= '0;
         flush      <= 1'b0;
         beat_count <= '0;
         size_err   <= 1'b0;
      end else begin
         data_buf <= buf_n;
         fill     <= fill_n;
         if (push && in_last) begin
            flush <= 1'b1;
         end else if (pop && out_last) begin
            flush <= 1'b0;
         end
         if (pop) begin
            beat_count <= beat_count + CNT_WIDTH'(1);
         end
         if (push && (in_size > FULL_S)) begin
            size_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fragment_packer.sv
// tb_fragment_packer: directed self-checking bench for fragment_packer.
// Each task drives one scenario and checks against hand-computed values.
module tb_fragment_packer;

   logic         clock;
   logic         resetn;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_data;
   logic [6:0]   in_size;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] out_data;
   logic [6:0]   out_bytes;
   logic         out_last;
   logic [7:0]   fill_level;
   logic [31:0]  beat_count;
   logic         size_err;

   int checks = 0;
   int errors = 0;

   fragment_packer dut (
      .clock      (clock),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_size    (in_size),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_bytes  (out_bytes),
      .out_last   (out_last),
      .fill_level (fill_level),
      .beat_count (beat_count),
      .size_err   (size_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // bytes start..start+n-1, zero above
   function automatic logic [511:0] seq(int start, int n);
      logic [511:0] b;
      b = '0;
      for (int i = 0; i < 64; i++)
         if (i < n) b[8*i +: 8] = 8'(start + i);
      return b;
   endfunction

   // same as seq but with 0xA5 garbage above n
   function automatic logic [511:0] frag(int start, int n);
      logic [511:0] b;
      b = seq(start, n);
      for (int i = 0; i < 64; i++)
         if (i >= n) b[8*i +: 8] = 8'hA5;
      return b;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_data  = '0;
      in_size  = '0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset();
      idle_in();
      out_ready = 1'b0;
      resetn = 1'b0;
      step();
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs got v=%b r=%b l=%b exp 0 0 0",
                  out_valid, in_ready, out_last);
      end
      checks++;
      if (fill_level !== 8'd0 || beat_count !== 32'd0 || size_err !== 1'b0
          || out_bytes !== 7'd0 || out_data !== 512'd0) begin
         errors++;
         $display("FAIL reset_state got fill=%0d cnt=%0d err=%b bytes=%0d",
                  fill_level, beat_count, size_err, out_bytes);
      end
      resetn = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got %b exp 1", in_ready);
      end
   endtask

   task automatic test_pack();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = frag(24*k, 24);
         in_size  = 7'd24;
         in_last  = 1'b0;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pack_ready%0d got %b exp 1", k, in_ready);
         end
         step();
      end
      idle_in();
      #1;
      checks++;
      if (fill_level !== 8'd72 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL pack_fill got fill=%0d v=%b r=%b exp 72 1 0",
                  fill_level, out_valid, in_ready);
      end
      checks++;
      if (out_data !== seq(0, 64) || out_bytes !== 7'd64 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL pack_beat got %h bytes=%0d last=%b exp bytes 00..3f 64 0",
                  out_data[63:0], out_bytes, out_last);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL pack_pop_ready got %b exp 1", in_ready);
      end
      step();
      out_ready = 1'b0;
      #1;
      checks++;
      if (fill_level !== 8'd8 || beat_count !== 32'd1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL pack_after_pop got fill=%0d cnt=%0d v=%b exp 8 1 0",
                  fill_level, beat_count, out_valid);
      end
      in_valid = 1'b1;
      in_size  = 7'd0;
      in_last  = 1'b1;
      in_data  = frag(0, 0);
      step();
      idle_in();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_last !== 1'b1 || out_bytes !== 7'd8
          || out_data !== seq(8'h40, 8) || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL pack_tail got v=%b l=%b bytes=%0d r=%b data=%h",
                  out_valid, out_last, out_bytes, in_ready, out_data[127:0]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      checks++;
      if (fill_level !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL pack_drained got fill=%0d v=%b r=%b exp 0 0 1",
                  fill_level, out_valid, in_ready);
      end
   endtask

   task automatic test_last();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = frag(8'h80, 24);
      in_size   = 7'd24;
      in_last   = 1'b1;
      step();
      idle_in();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_bytes !== 7'd24 || out_last !== 1'b1
          || out_data !== seq(8'h80, 24)) begin
         errors++;
         $display("FAIL last_beat got v=%b bytes=%0d l=%b data=%h",
                  out_valid, out_bytes, out_last, out_data[255:0]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || fill_level !== 8'd0 || out_valid !== 1'b0
          || beat_count !== 32'd3) begin
         errors++;
         $display("FAIL last_after got r=%b fill=%0d v=%b cnt=%0d exp 1 0 0 3",
                  in_ready, fill_level, out_valid, beat_count);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_last   = 1'b0;
      in_data   = frag(0, 60);
      in_size   = 7'd60;
      step();
      in_data   = frag(60, 40);
      in_size   = 7'd40;
      step();
      in_data   = frag(100, 40);
      in_size   = 7'd40;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || fill_level !== 8'd100
             || out_data !== seq(0, 64) || out_bytes !== 7'd64) begin
            errors++;
            $display("FAIL bp_stall%0d got r=%b fill=%0d bytes=%0d", c,
                     in_ready, fill_level, out_bytes);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_same_cycle_ready got %b exp 1", in_ready);
      end
      step();
      idle_in();
      out_ready = 1'b0;
      #1;
      checks++;
      if (fill_level !== 8'd76 || out_valid !== 1'b1
          || out_data !== seq(64, 64)) begin
         errors++;
         $display("FAIL bp_after_push got fill=%0d v=%b data=%h exp 76 1",
                  fill_level, out_valid, out_data[63:0]);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_size   = 7'd0;
      in_last   = 1'b1;
      step();
      idle_in();
      #1;
      checks++;
      if (out_bytes !== 7'd12 || out_last !== 1'b1
          || out_data !== seq(128, 12)) begin
         errors++;
         $display("FAIL bp_tail got bytes=%0d l=%b data=%h exp 12 1",
                  out_bytes, out_last, out_data[127:0]);
      end
      step();
      out_ready = 1'b0;
      #1;
      checks++;
      if (fill_level !== 8'd0 || out_valid !== 1'b0 || beat_count !== 32'd6) begin
         errors++;
         $display("FAIL bp_drained got fill=%0d v=%b cnt=%0d exp 0 0 6",
                  fill_level, out_valid, beat_count);
      end
   endtask

   task automatic test_back_to_back();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      #1;
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_valid = 1'b1;
         in_data  = frag(k * 3, 64);
         in_size  = 7'd64;
         in_last  = 1'b0;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready%0d got %b exp 1", k, in_ready);
         end
         if (k > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== seq((k-1) * 3, 64)) begin
               errors++;
               $display("FAIL b2b_beat%0d got v=%b data=%h", k,
                        out_valid, out_data[63:0]);
            end
         end
         step();
      end
      in_valid = 1'b1;
      in_data  = '0;
      in_size  = 7'd0;
      in_last  = 1'b1;
      step();
      idle_in();
      #1;
      checks++;
      if (beat_count !== 32'd16 || out_valid !== 1'b1 || out_last !== 1'b1
          || out_bytes !== 7'd0 || out_data !== 512'd0) begin
         errors++;
         $display("FAIL b2b_empty got cnt=%0d v=%b l=%b bytes=%0d",
                  beat_count, out_valid, out_last, out_bytes);
      end
      step();
      out_ready = 1'b0;
      #1;
      checks++;
      if (beat_count !== 32'd17 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done got cnt=%0d v=%b r=%b exp 17 0 1",
                  beat_count, out_valid, in_ready);
      end
   endtask

   task automatic test_size_err();
      out_ready = 1'b0;
      checks++;
      if (size_err !== 1'b0) begin
         errors++;
         $display("FAIL serr_initial got %b exp 0", size_err);
      end
      in_valid = 1'b1;
      in_data  = frag(8'h10, 64);
      in_size  = 7'd70;
      in_last  = 1'b0;
      step();
      idle_in();
      #1;
      checks++;
      if (size_err !== 1'b1 || fill_level !== 8'd64
          || out_data !== seq(8'h10, 64)) begin
         errors++;
         $display("FAIL serr_set got err=%b fill=%0d exp 1 64",
                  size_err, fill_level);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = frag(8'h55, 8);
      in_size   = 7'd8;
      in_last   = 1'b1;
      step();
      idle_in();
      #1;
      checks++;
      if (size_err !== 1'b1 || out_bytes !== 7'd8 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL serr_sticky got err=%b bytes=%0d l=%b exp 1 8 1",
                  size_err, out_bytes, out_last);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = frag(1, 50);
      in_size   = 7'd50;
      in_last   = 1'b1;
      step();
      idle_in();
      #1;
      checks++;
      if (fill_level !== 8'd50 || out_valid !== 1'b1 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre got fill=%0d v=%b l=%b exp 50 1 1",
                  fill_level, out_valid, out_last);
      end
      #1;
      resetn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0
          || out_bytes !== 7'd0 || out_data !== 512'd0
          || fill_level !== 8'd0 || beat_count !== 32'd0) begin
         errors++;
         $display("FAIL arst_now got v=%b r=%b l=%b bytes=%0d fill=%0d",
                  out_valid, in_ready, out_last, out_bytes, fill_level);
      end
      @(negedge clock);
      resetn = 1'b1;
      step();
      in_valid = 1'b1;
      in_data  = frag(8'h30, 8);
      in_size  = 7'd8;
      in_last  = 1'b1;
      step();
      idle_in();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_bytes !== 7'd8 || out_last !== 1'b1
          || out_data !== seq(8'h30, 8)) begin
         errors++;
         $display("FAIL arst_clean got v=%b bytes=%0d l=%b exp 1 8 1",
                  out_valid, out_bytes, out_last);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || beat_count !== 32'd1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL arst_done got v=%b cnt=%0d r=%b exp 0 1 1",
                  out_valid, beat_count, in_ready);
      end
   endtask

   initial begin
      resetn    = 1'b0;
      out_ready = 1'b0;
      idle_in();
      test_reset();
      test_pack();
      test_last();
      test_backpressure();
      test_back_to_back();
      test_size_err();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
